// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low polarities, blank pattern and the
// 16 hex glyphs, stored as segments g..a with a segment on when its bit is 0.
package seg_pkg;

  localparam logic SEG_ACTIVE   = 1'b0;
  localparam logic SEG_INACTIVE = 1'b1;
  localparam logic DIG_ACTIVE   = 1'b0;
  localparam logic DIG_INACTIVE = 1'b1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [0:15][6:0] SEG_GLYPH = {
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble + decimal-point to active-low segment pattern
// (bit7 = DP, bits 6..0 = g..a).
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_pattern
);

  assign o_pattern = {(i_dp ? SEG_ACTIVE : SEG_INACTIVE), SEG_GLYPH[i_nibble]};

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed hex display driver with double-buffered data, PWM brightness and
// leading-zero blanking; digit blinking is built only with SEG_DISPLAY_MUX_BLINK_EN.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int PWM_BITS    = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  Clk_100M,
  input  logic                  Reset_Button,
  input  logic [4*DIGITS-1:0]   Digit_Data,
  input  logic [DIGITS-1:0]     DP_Data,
  input  logic                  Load,
  input  logic                  Lz_Blank,
  input  logic [PWM_BITS-1:0]   Brightness,
  input  logic [DIGITS-1:0]     Blink_Mask,
  output logic                  Pending,
  output logic [DIGITS-1:0]     SegmentDrivers,
  output logic [7:0]            SevenSegment
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [RW-1:0]         r_refresh_cnt;
  logic [IW-1:0]         r_digit_idx;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [4*DIGITS-1:0]   r_shadow_data;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_active_data;
  logic [DIGITS-1:0]     r_active_dp;
  logic                  r_pending;
  logic [DIGITS-1:0]     r_seg_drv;
  logic [7:0]            r_seven_seg;

  logic                  w_slot_end;
  logic                  w_frame_wrap;
  logic [3:0]            w_nibble;
  logic                  w_dp;
  logic [7:0]            w_decoded;
  logic [DIGITS-1:0]     w_lead_zero;
  logic                  w_zero_run;
  logic                  w_blank;
  logic [7:0]            w_pattern;
  logic                  w_drv_on;
  logic [DIGITS-1:0]     w_drivers;
  logic                  w_blink_off;

  assign w_slot_end   = (r_refresh_cnt == REF_LAST);
  assign w_frame_wrap = w_slot_end && (r_digit_idx == IDX_LAST);

  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_pwm_cnt     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_slot_end) begin
        r_refresh_cnt <= '0;
        r_digit_idx   <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
    end
  end

  // A Load on the wrap cycle bypasses the shadow so it lands in this frame.
  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_active_data <= '0;
      r_active_dp   <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (Load) begin
        r_shadow_data <= Digit_Data;
        r_shadow_dp   <= DP_Data;
      end
      if (w_frame_wrap) begin
        r_active_data <= Load ? Digit_Data : r_shadow_data;
        r_active_dp   <= Load ? DP_Data : r_shadow_dp;
        r_pending     <= 1'b0;
      end else if (Load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_nibble = r_active_data[4*r_digit_idx +: 4];
  assign w_dp     = r_active_dp[r_digit_idx];

  seg_decoder u_decoder (
    .i_nibble  (w_nibble),
    .i_dp      (w_dp),
    .o_pattern (w_decoded)
  );

  // w_lead_zero[i]: every nibble from the top digit down to i is zero.
  always_comb begin
    w_lead_zero = '0;
    w_zero_run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_run     = w_zero_run && (r_active_data[4*i +: 4] == 4'h0);
      w_lead_zero[i] = w_zero_run;
    end
  end

  assign w_blank   = Lz_Blank && (r_digit_idx != '0) && w_lead_zero[r_digit_idx];
  assign w_pattern = w_blank ? {w_decoded[7], SEG_BLANK[6:0]} : w_decoded;

  always_comb begin
    w_drv_on  = (&Brightness) || (r_pwm_cnt < Brightness);
    w_drivers = {DIGITS{DIG_INACTIVE}};
    if (w_drv_on) begin
      w_drivers[r_digit_idx] = DIG_ACTIVE;
    end
  end

`ifdef SEG_DISPLAY_MUX_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Phase 1 is the dark half; the driver keeps scanning so timing is unchanged.
  assign w_blink_off = r_blink_phase && Blink_Mask[r_digit_idx];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^Blink_Mask;
  assign w_blink_off    = 1'b0;
`endif

  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      r_seg_drv   <= {DIGITS{DIG_INACTIVE}};
      r_seven_seg <= SEG_BLANK;
    end else begin
      r_seg_drv   <= w_drivers;
      r_seven_seg <= w_blink_off ? SEG_BLANK : w_pattern;
    end
  end

  assign Pending        = r_pending;
  assign SegmentDrivers = r_seg_drv;
  assign SevenSegment   = r_seven_seg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: directed scenarios plus random traffic,
// every output compared each cycle against a time-indexed behavioural model.
module tb_seg_display_mux;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int PWM_BITS    = 2;
  localparam int BLINK_DIV   = 8;
  localparam int FRAME       = REFRESH_DIV * DIGITS;
`ifdef SEG_DISPLAY_MUX_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                Reset_Button;
  logic [15:0]         Digit_Data;
  logic [3:0]          DP_Data;
  logic                Load;
  logic                Lz_Blank;
  logic [1:0]          Brightness;
  logic [3:0]          Blink_Mask;
  logic                Pending;
  logic [3:0]          SegmentDrivers;
  logic [7:0]          SevenSegment;

  int errors = 0;
  int checks = 0;

  int unsigned m_t;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_shadow_dp, m_active_dp;
  logic        m_pending;

  seg_display_mux #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .PWM_BITS(PWM_BITS), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .Clk_100M       (clk),
    .Reset_Button   (Reset_Button),
    .Digit_Data     (Digit_Data),
    .DP_Data        (DP_Data),
    .Load           (Load),
    .Lz_Blank       (Lz_Blank),
    .Brightness     (Brightness),
    .Blink_Mask     (Blink_Mask),
    .Pending        (Pending),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Active-high a..g segments of the standard hex glyphs.
  function automatic logic [6:0] glyph_hi(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] exp_drv(input int unsigned t, input logic [1:0] br);
    int idx;
    int pwm;
    idx = (t / REFRESH_DIV) % DIGITS;
    pwm = t % (1 << PWM_BITS);
    if (br == 2'b11 || pwm < int'(br)) return ~(4'b0001 << idx);
    return 4'hF;
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned t, input logic [15:0] act,
                                         input logic [3:0] dp, input logic lz,
                                         input logic [3:0] bmask);
    int idx;
    logic [7:0] s;
    idx = (t / REFRESH_DIV) % DIGITS;
    if (lz && idx != 0 && (act >> (4 * idx)) == 16'h0)
      s = {~dp[idx], 7'h7F};
    else
      s = {~dp[idx], ~glyph_hi(act[4*idx +: 4])};
    if (BLINK_BUILT && ((t / BLINK_DIV) % 2) == 1 && bmask[idx]) s = 8'hFF;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e_drv;
    logic [7:0] e_seg;
    logic       wrap;
    @(posedge clk);
    if (Reset_Button) begin
      e_drv = 4'hF;
      e_seg = 8'hFF;
      m_t = 0;
      m_shadow = '0; m_active = '0; m_shadow_dp = '0; m_active_dp = '0;
      m_pending = 1'b0;
    end else begin
      e_drv = exp_drv(m_t, Brightness);
      e_seg = exp_seg(m_t, m_active, m_active_dp, Lz_Blank, Blink_Mask);
      wrap  = (m_t % FRAME) == FRAME - 1;
      if (Load) begin
        m_shadow    = Digit_Data;
        m_shadow_dp = DP_Data;
      end
      if (wrap) begin
        m_active    = m_shadow;
        m_active_dp = m_shadow_dp;
        m_pending   = 1'b0;
      end else if (Load) begin
        m_pending = 1'b1;
      end
      m_t++;
    end
    @(negedge clk);
    check("model_drivers", SegmentDrivers, e_drv);
    check("model_segments", SevenSegment, e_seg);
    check("model_pending", Pending, m_pending);
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) tick();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    Digit_Data = d;
    DP_Data    = dp;
    Load       = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  task automatic wait_commit(input string tag);
    for (int i = 0; i < 3 * FRAME && Pending !== 1'b0; i++) tick();
    check(tag, Pending, 1'b0);
  endtask

  task automatic expect_digit(input int idx, input logic [7:0] pat, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 4 && !found; i++) begin
      tick();
      if (SegmentDrivers === ~(4'b0001 << idx)) found = 1'b1;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) check(tag, SevenSegment, pat);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++)
      d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    int cnt;
    Reset_Button = 1'b1;
    Digit_Data = '0; DP_Data = '0; Load = 1'b0; Lz_Blank = 1'b0;
    Brightness = 2'b11; Blink_Mask = '0;
    m_t = 0; m_shadow = '0; m_active = '0; m_shadow_dp = '0; m_active_dp = '0; m_pending = 1'b0;

    // reset
    tick(); tick(); tick();
    check("reset_drivers", SegmentDrivers, 4'b1111);
    check("reset_segments", SevenSegment, 8'hFF);
    check("reset_pending", Pending, 1'b0);
    Reset_Button = 1'b0;

    // commit timing
    align(6);
    load(16'h1234, 4'b0000);
    check("commit_pending_set", Pending, 1'b1);
    wait_commit("commit_pending_clear");
    expect_digit(0, 8'b1001_1001, "commit_digit0");
    expect_digit(3, 8'hF9, "commit_digit3");

    // brightness duty over one full PWM multiple
    Brightness = 2'b01; cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(); if (SegmentDrivers !== 4'hF) cnt++; end
    check("bright_01_on_count", cnt, 4);
    Brightness = 2'b00; cnt = 0;
    tick();
    for (int i = 0; i < 16; i++) begin tick(); if (SegmentDrivers !== 4'hF) cnt++; end
    check("bright_00_on_count", cnt, 0);
    Brightness = 2'b11; cnt = 0;
    tick();
    for (int i = 0; i < 16; i++) begin tick(); if (SegmentDrivers !== 4'hF) cnt++; end
    check("bright_11_on_count", cnt, 16);

    // leading-zero blanking
    Lz_Blank = 1'b1;
    load(16'h0050, 4'b0000);
    wait_commit("lz_commit");
    expect_digit(0, 8'hC0, "lz_digit0");
    expect_digit(1, 8'h92, "lz_digit1");
    expect_digit(2, 8'hFF, "lz_digit2");
    expect_digit(3, 8'hFF, "lz_digit3");
    load(16'h0050, 4'b1000);
    wait_commit("lz_dp_commit");
    expect_digit(3, 8'h7F, "lz_digit3_dp");
    Lz_Blank = 1'b0;

    // overwrite while pending
    align(2);
    load(16'hAAAA, 4'b0000);
    check("ovw_pending", Pending, 1'b1);
    align(6);
    load(16'hBBBB, 4'b0000);
    wait_commit("ovw_commit");
    expect_digit(0, 8'h83, "ovw_digit0");
    expect_digit(3, 8'h83, "ovw_digit3");

    // load on the wrap cycle
    align(FRAME - 1);
    load(16'hCDEF, 4'b0000);
    check("coinc_pending", Pending, 1'b0);
    expect_digit(0, 8'h8E, "coinc_digit0");
    expect_digit(3, 8'hC6, "coinc_digit3");

    if (BLINK_BUILT) begin
      Blink_Mask = 4'b1111; cnt = 0;
      tick();
      for (int i = 0; i < 16; i++) begin tick(); if (SevenSegment === 8'hFF) cnt++; end
      check("blink_dark_count", cnt, 8);
      Blink_Mask = 4'b0001;
      for (int i = 0; i < 32; i++) tick();
      Blink_Mask = 4'b0000;
    end

    // reset mid-frame discards a pending load and restarts at digit 0
    align(5);
    load(16'h9999, 4'b1111);
    Reset_Button = 1'b1;
    tick();
    Reset_Button = 1'b0;
    check("midreset_pending", Pending, 1'b0);
    tick();
    check("midreset_restart_drv", SegmentDrivers, 4'b1110);
    check("midreset_restart_seg", SevenSegment, 8'hC0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      Reset_Button = ($urandom_range(0, 299) == 0);
      Load = ($urandom_range(0, 5) == 0);
      if (Load) begin
        Digit_Data = rand_digits();
        DP_Data    = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) Brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) Lz_Blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) Blink_Mask = 4'($urandom_range(0, 15));
      tick();
    end
    Reset_Button = 1'b0;
    Load = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
